// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, requester identifiers and the latency counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Wide enough for LATENCY-1 with LATENCY up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes, shared read data and the memory-side bus of the
// arbiter, bundled so the arbiter and its environment share one definition.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;

    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              grant;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, d_ack, rdata, busy, grant,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, d_ack, rdata, busy, grant,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// and on a tie the requester that was not granted last time wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       winner
);

    always_comb begin
        any    = |req;
        winner = REQ_FETCH;
        case (req)
            2'b01:   winner = REQ_FETCH;
            2'b10:   winner = REQ_DATA;
            2'b11:   winner = ~last;
            default: winner = REQ_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between instruction fetch and data access:
// round-robin grant, fixed-latency access, one-cycle ack with read data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 1
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_arbiter: LATENCY must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    arb_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              grant_q, grant_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              we_q, we_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              pick_any;
    logic              pick_winner;

    rr_arb2 u_pick (
        .req    ({bus.d_req, bus.f_req}),
        .last   (grant_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Grant resets to DATA so that FETCH wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            grant_q <= REQ_DATA;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            cnt     <= cnt_n;
            grant_q <= grant_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant_n = grant_q;
        addr_n  = addr_q;
        we_n    = we_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_n = ARB_BUSY;
                    cnt_n   = CNT_INIT;
                    grant_n = pick_winner;
                    if (pick_winner == REQ_DATA) begin
                        addr_n  = bus.d_addr;
                        we_n    = bus.d_we;
                        wdata_n = bus.d_wdata;
                    end else begin
                        addr_n  = bus.f_addr;
                        we_n    = 1'b0;
                        wdata_n = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (cnt == '0) begin
                    rdata_n = bus.mem_rdata;
                    we_n    = 1'b0;
                    state_n = ARB_ACK;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ARB_ACK: begin
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    assign bus.mem_en    = (state == ARB_BUSY);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state != ARB_IDLE);
    assign bus.grant     = grant_q;
    assign bus.f_ack     = (state == ARB_ACK) && (grant_q == REQ_FETCH);
    assign bus.d_ack     = (state == ARB_ACK) && (grant_q == REQ_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: requester drivers push expected
// transactions, a negedge monitor checks bus timing, grant order and read data.
module tb_mem_arbiter;

    localparam int LATENCY = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_POST = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    txn_t fq[$];
    txn_t dq[$];
    logic [15:0] ram [512];
    logic [15:0] model_mem [512];

    logic snap_f = 1'b0;
    logic snap_d = 1'b0;
    logic mon_on = 1'b0;
    logic model_last = 1'b1;
    logic cur_w = 1'b0;
    txn_t cur;
    int   phase = PH_IDLE;
    int   left = 0;

    // Behavioural memory: combinational read, write on each busy edge
    assign bus.mem_rdata = ram[bus.mem_addr[8:0]];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
    end

    always @(posedge clk) begin
        snap_f = bus.f_req;
        snap_d = bus.d_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: any sampled request in idle starts LATENCY busy cycles,
    // then one ack cycle, then at least one idle cycle
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            case (phase)
                PH_IDLE: begin
                    if (snap_f || snap_d) begin
                        cur_w = (snap_f && snap_d) ? !model_last : snap_d;
                        model_last = cur_w;
                        check("start_en", 32'(bus.mem_en), 32'(1));
                        check("grant", 32'(bus.grant), 32'(cur_w));
                        if ((cur_w ? dq.size() : fq.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL sb_empty: grant %0d with nothing expected at %0t", cur_w, $time);
                            cur = '0;
                        end else begin
                            cur = cur_w ? dq[0] : fq[0];
                        end
                        check("addr", 32'(bus.mem_addr), 32'(cur.addr));
                        check("we", 32'(bus.mem_we), 32'(cur.we));
                        check("wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
                        left = LATENCY - 1;
                        phase = PH_BUSY;
                    end else begin
                        check("idle_busy", 32'(bus.busy), 32'(0));
                        check("idle_en", 32'(bus.mem_en), 32'(0));
                        check("idle_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
                    end
                end
                PH_BUSY: begin
                    if (left > 0) begin
                        check("busy_en", 32'(bus.mem_en), 32'(1));
                        check("busy_addr", 32'(bus.mem_addr), 32'(cur.addr));
                        check("busy_we", 32'(bus.mem_we), 32'(cur.we));
                        check("busy_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
                        check("busy_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
                        left--;
                    end else begin
                        check("ack_en", 32'({bus.mem_en, bus.mem_we}), 32'(0));
                        check("ack_busy", 32'(bus.busy), 32'(1));
                        check("f_ack", 32'(bus.f_ack), 32'(!cur_w));
                        check("d_ack", 32'(bus.d_ack), 32'(cur_w));
                        if (!cur.we) check("rdata", 32'(bus.rdata), 32'(cur.rdata));
                        if (cur_w && dq.size() > 0) void'(dq.pop_front());
                        if (!cur_w && fq.size() > 0) void'(fq.pop_front());
                        phase = PH_POST;
                    end
                end
                default: begin
                    check("post_busy", 32'(bus.busy), 32'(0));
                    check("post_en", 32'(bus.mem_en), 32'(0));
                    check("post_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
                    phase = PH_IDLE;
                end
            endcase
        end
    end

    task automatic wait_ack(input logic who, input logic [15:0] alt);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((who ? bus.d_ack : bus.f_ack) === 1'b1) begin
                done = 1;
            end else if (bus.busy && bus.grant == who) begin
                if (who) begin
                    bus.d_addr  = alt;
                    bus.d_wdata = ~alt;
                end else begin
                    bus.f_addr = alt;
                end
            end
        end
        if (who) bus.d_req = 1'b0;
        else     bus.f_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: requester %0d got no ack, required one within 60 cycles", who);
        end
    endtask

    task automatic fetch_txn(input logic [15:0] addr, input logic [15:0] alt);
        txn_t t;
        t.addr  = addr;
        t.we    = 1'b0;
        t.wdata = '0;
        t.rdata = model_mem[addr[8:0]];
        fq.push_back(t);
        bus.f_addr = addr;
        bus.f_req  = 1'b1;
        wait_ack(1'b0, alt);
    endtask

    task automatic data_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] alt);
        txn_t t;
        t.addr  = addr;
        t.we    = we;
        t.wdata = wdata;
        t.rdata = model_mem[addr[8:0]];
        if (we) model_mem[addr[8:0]] = wdata;
        dq.push_back(t);
        bus.d_addr  = addr;
        bus.d_we    = we;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        wait_ack(1'b1, alt);
    endtask

    task automatic applyStimulus();
        bit seen;
        // Directed: fetch, store, long load, address change in flight
        fetch_txn(16'h0004, 16'h0005);
        data_txn(1'b1, 16'h0010, 16'h1234, 16'h0011);
        data_txn(1'b0, 16'h00FF, 16'h0000, 16'h00FE);
        data_txn(1'b0, 16'h0020, 16'h0000, 16'h0030);
        fetch_txn(16'h0010, 16'h0012);
        repeat (3) @(negedge clk);

        // Abort a fetch with reset while it is busy
        mon_on = 1'b0;
        bus.f_addr = 16'h0040;
        bus.f_req  = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_en) seen = 1;
        end
        check("abort_started", 32'(seen), 32'(1));
        @(negedge clk);
        rst_n = 1'b0;
        bus.f_req = 1'b0;
        #1;
        check("rst_en", 32'({bus.mem_en, bus.mem_we}), 32'(0));
        check("rst_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_grant", 32'(bus.grant), 32'(1));
        check("rst_addr", 32'(bus.mem_addr), 32'(0));
        fq.delete();
        dq.delete();
        phase = PH_IDLE;
        model_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
        end
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Contention straight after reset: F, D, F, D, back to back
        fork
            for (int i = 0; i < 4; i++) fetch_txn(16'h0080 + 16'(i), 16'h0090);
            for (int i = 0; i < 4; i++) data_txn(1'b0, 16'h0100 + 16'(i), 16'h0, 16'h01F0);
        join

        // Random traffic: fetches in 0x000-0x0FF, data in 0x100-0x1FF
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                fetch_txn(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
            end
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                data_txn(1'($urandom_range(0, 1)), 16'h0100 | 16'($urandom_range(0, 255)),
                         16'($urandom), 16'($urandom));
            end
        join
    endtask

    task automatic checkOutput();
        repeat (4) @(negedge clk);
        check("drain", 32'(fq.size() + dq.size()), 32'(0));
        check("final_busy", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            ram[a]       = 16'(a * 40503) ^ 16'h5A5A;
            model_mem[a] = 16'(a * 40503) ^ 16'h5A5A;
        end
        ram[4]       = 16'hBEEF;
        model_mem[4] = 16'hBEEF;
        rst_n       = 1'b0;
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_grant", 32'(bus.grant), 32'(1));
        check("reset_mem", 32'({bus.mem_en, bus.mem_we}), 32'(0));
        check("reset_addr", 32'(bus.mem_addr), 32'(0));
        check("reset_wdata", 32'(bus.mem_wdata), 32'(0));
        check("reset_rdata", 32'(bus.rdata), 32'(0));
        check("reset_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
        rst_n  = 1'b1;
        mon_on = 1'b1;
        applyStimulus();
        checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
